// File: rtl/shift_pkg.sv
// shift_pkg: operation encoding shared by the universal shift register and its bench
package shift_pkg;
    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHL   = 3'd1,
        MODE_SHR   = 3'd2,
        MODE_ROL   = 3'd3,
        MODE_ROR   = 3'd4,
        MODE_LOAD  = 3'd5,
        MODE_CLEAR = 3'd6,
        MODE_RSVD  = 3'd7
    } usr_mode_t;

    function automatic logic is_shift(input usr_mode_t m);
        return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR};
    endfunction

    function automatic logic is_restart(input usr_mode_t m);
        return m inside {MODE_LOAD, MODE_CLEAR};
    endfunction
endpackage

// File: rtl/shift_frame_counter.sv
// shift_frame_counter: counts shifts per WIDTH-long frame and pulses frame_done on completion
module shift_frame_counter #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          en,
    input  logic          shift,
    input  logic          restart,
    output logic [CW-1:0] count,
    output logic          frame_done
);
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          last;

    assign last = count_q == CW'(WIDTH - 1);

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (en && restart) count_d = '0;
        else if (en && shift) begin
            count_d = last ? '0 : count_q + 1'b1;
            done_d  = last;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count      = count_q;
    assign frame_done = done_q;
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: shift/rotate/load/clear register with serial taps and frame tracking
module universal_shift_register
    import shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  usr_mode_t        MODE,
    input  logic             DATA_IN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SER_OUT_L,
    output logic             SER_OUT_R,
    output logic [CW-1:0]    COUNT,
    output logic             FRAME_DONE
);
    logic [WIDTH-1:0] q_q;

    // all datapath muxing lives in this one clocked process; reserved mode falls to hold
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) q_q <= RESET_VALUE;
        else if (EN) begin
            case (MODE)
                MODE_SHL:   q_q <= {q_q[WIDTH-2:0], DATA_IN};
                MODE_SHR:   q_q <= {DATA_IN, q_q[WIDTH-1:1]};
                MODE_ROL:   q_q <= {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:   q_q <= {q_q[0], q_q[WIDTH-1:1]};
                MODE_LOAD:  q_q <= D;
                MODE_CLEAR: q_q <= RESET_VALUE;
                default:    q_q <= q_q;
            endcase
        end
    end

    shift_frame_counter #(.WIDTH(WIDTH)) u_frame (
        .CLK        (CLK),
        .RESET      (RESET),
        .en         (EN),
        .shift      (is_shift(MODE)),
        .restart    (is_restart(MODE)),
        .count      (COUNT),
        .frame_done (FRAME_DONE)
    );

    assign Q         = q_q;
    assign SER_OUT_L = q_q[WIDTH-1];
    assign SER_OUT_R = q_q[0];
endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VALUE, default all zeros, WIDTH-bit value loaded into Q on reset.
REQ-003 SHALL have port CLK  input  1  clock, rising-edge active.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port EN  input  1  operation enable; low means hold.
REQ-006 SHALL have port MODE  input  3  operation select, encoded as usr_mode_t.
REQ-007 SHALL have port DATA_IN  input  1  serial input bit.
REQ-008 SHALL have port D  input  WIDTH  parallel load data.
REQ-009 SHALL have port Q  output  WIDTH  register contents.
REQ-010 SHALL have port SER_OUT_L  output  1  equal to Q[WIDTH-1], combinational.
REQ-011 SHALL have port SER_OUT_R  output  1  equal to Q[0], combinational.
REQ-012 SHALL have port COUNT  output  $clog2(WIDTH+1)  number of shifts in the current frame.
REQ-013 SHALL have port FRAME_DONE  output  1  registered one-cycle pulse marking frame completion.

Function
REQ-014 SHALL evaluate all operations on the rising CLK edge, and only when EN=1; when EN=0, Q, COUNT and FRAME_DONE-generation state SHALL hold, and FRAME_DONE SHALL be 0.
REQ-015 SHALL decode MODE as follows: HOLD=0, SHL=1, SHR=2, ROL=3, ROR=4, LOAD=5, CLEAR=6.
REQ-016 SHALL implement SHL as Q <= {Q[WIDTH-2:0], DATA_IN}.
REQ-017 SHALL implement SHR as Q <= {DATA_IN, Q[WIDTH-1:1]}.
REQ-018 SHALL implement ROL as Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}, and ROR as Q <= {Q[0], Q[WIDTH-1:1]}.
REQ-019 SHALL implement LOAD as Q <= D and COUNT <= 0.
REQ-020 SHALL implement CLEAR as Q <= RESET_VALUE and COUNT <= 0 (synchronous clear).
REQ-021 SHALL treat MODE=7 (reserved) as HOLD.
REQ-022 SHALL increment COUNT by 1 on each enabled SHL, SHR, ROL or ROR operation.
REQ-023 SHALL, on the shift that takes COUNT from WIDTH-1 to WIDTH, instead set COUNT <= 0 and FRAME_DONE <= 1 for exactly the following cycle.
REQ-024 SHALL hold FRAME_DONE at 0 in every cycle not covered by REQ-023, including back-to-back frames; a new pulse occurs only after another WIDTH shifts.
REQ-025 SHALL not produce a FRAME_DONE pulse from LOAD or CLEAR, even if the frame is partially complete.
REQ-026 SHALL make Q visible with 1-cycle latency from the enabling edge, with no combinational path from the inputs to Q.

Reset
REQ-027 SHALL, while RESET=0, force Q=RESET_VALUE, COUNT=0 and FRAME_DONE=0 immediately, independent of CLK.
REQ-028 SHALL discard any partial frame when reset is applied mid-operation; counting restarts from 0 after release.
REQ-029 SHALL resume normal operation on the first rising edge after RESET deasserts.

Structure
REQ-030 SHALL define the usr_mode_t enum (3-bit) and its mode constants in shared package shift_pkg.
REQ-031 SHALL implement the frame counter and FRAME_DONE logic in sub-module shift_frame_counter, parameterised by WIDTH.
REQ-032 SHALL build all datapath muxing in a single clocked process with one registered Q vector; per-bit hand-written assignments are not permitted.

Verification (WIDTH=8, RESET_VALUE=0)
REQ-033 SHALL cover: reset, then EN=1 with SHL and serial bits 1,0,1,1,0,0,1,0 -> Q=8'hB2, FRAME_DONE high for one cycle after the 8th edge, COUNT=0.
REQ-034 SHALL cover: LOAD 8'hA5, then SHR with DATA_IN=0 -> SER_OUT_R=1 before the edge, Q=8'h52 and COUNT=1 after it.
REQ-035 SHALL cover: LOAD 8'h81, then ROL -> Q=8'h03; LOAD 8'h81, then ROR -> Q=8'hC0.
REQ-036 SHALL cover: EN=0 with MODE=SHL for 3 cycles -> Q and COUNT unchanged, FRAME_DONE=0; MODE=7 with EN=1 -> hold.
REQ-037 SHALL cover: 5 shifts, then assert RESET between edges -> Q=8'h00 and COUNT=0 at once; after release, 8 shifts are needed for FRAME_DONE.
REQ-038 SHALL cover: 7 shifts, then LOAD 8'h3C -> COUNT=0, no FRAME_DONE, Q=8'h3C; then 7 shifts followed by CLEAR -> Q=8'h00, no pulse.
